pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL wrapper. It consumes the PLL `locked` flag and runs on the PLL output clock.
- Synchronises and qualifies `locked`, then holds the processor core in reset until lock has been stable for a programmable time plus a programmable reset-hold period.
- Drives the single registered reset for the sail-core pipeline. It re-asserts that reset immediately whenever lock is lost, or when software requests a soft reset.

Parameters:
- SYNC_STAGES, 2: number of flip-flops in the `locked` synchroniser chain (minimum 2).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles `locked_sync` must stay high before reset release begins (minimum 1).
- RESET_HOLD_CYCLES, 16: further cycles `core_reset` stays asserted after lock qualifies (minimum 1).
- CNT_W, 16: width of the shared cycle counter. It must hold max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)-1.

Ports:
- clk  input  1  PLL output clock (PLLOUTCORE); the only clock.
- reset  input  1  synchronous, active-high block reset (board power-on/button reset, already synchronised).
- pll_locked  input  1  raw PLL LOCK flag; treated as asynchronous.
- soft_reset_req  input  1  single-cycle pulse requesting a core reset without waiting for re-lock.
- core_reset  output  1  registered, active-high reset to the core.
- core_ready  output  1  registered; high exactly when core_reset is low.
- seq_state  output  2  current state encoding, for debug/LED.
- lock_loss_count  output  8  lock-loss event count; see Optional Feature.

Behaviour:
- Reset (reset=1 at a clk edge):
  - synchroniser flops, counter and lock_loss_count go to 0;
  - state goes to WAIT_LOCK;
  - core_reset=1, core_ready=0.
  - Reset mid-operation from any state gives the same result on the next edge.
- Synchroniser: `locked_sync` is the last of SYNC_STAGES flops fed by pll_locked.
- State encoding: WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3.
- WAIT_LOCK:
  - counter held at 0;
  - locked_sync=1 -> STABILIZE.
- STABILIZE:
  - locked_sync=0 -> WAIT_LOCK, counter cleared (any glitch restarts qualification);
  - otherwise counter increments;
  - when counter==LOCK_STABLE_CYCLES-1 -> HOLD, counter cleared.
- HOLD:
  - locked_sync=0 -> WAIT_LOCK;
  - otherwise counter increments;
  - when counter==RESET_HOLD_CYCLES-1 -> RUN, counter cleared.
- RUN:
  - locked_sync=0 -> WAIT_LOCK; this takes priority over soft_reset_req;
  - else soft_reset_req=1 -> HOLD, counter cleared.
  - soft_reset_req is ignored in every state other than RUN.
- core_reset is registered from next-state: it is 0 iff next state is RUN. core_ready is its complement, registered alongside it.
- Release latency: numbering the first edge that samples pll_locked=1 as edge 1, with a steady lock, core_reset falls at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES.
- Lock-loss latency: pll_locked falling while in RUN asserts core_reset at edge SYNC_STAGES+1.
- Soft reset: core_reset is high from the edge after the request for exactly RESET_HOLD_CYCLES cycles.
- Counter never wraps; it is cleared on every state change.
- No combinational path from any input to any output.

Optional Feature:
- Macro PLL_LOCK_LOSS_COUNT_EN.
- Defined:
  - lock_loss_count is an 8-bit counter, incrementing on every RUN->WAIT_LOCK transition;
  - it saturates at 255 and is cleared only by reset;
  - soft-reset transitions do not count.
- Undefined: lock_loss_count is tied to 8'd0 and no counter logic is built.

Decomposition:
- Package pll_reset_pkg holds:
  - state typedef and its encodings;
  - LOSS_CNT_W=8 and LOSS_CNT_MAX=255.
- One sub-module, lock_sync: a parameterised SYNC_STAGES flop chain with synchronous reset to 0. It is reusable for other asynchronous flags.

Test Plan:
- SYNC_STAGES=2, L=8, H=4; reset for 3 cycles, then pll_locked=1 steady -> core_reset=1 through edge 14, falls at edge 15; core_ready rises at edge 15; seq_state walks 0,1,2,3.
- During STABILIZE, pll_locked low for 1 cycle at count 5 -> return to WAIT_LOCK. Release is re-timed from re-lock and takes a full 15 edges again.
- In RUN, drop pll_locked -> core_reset=1 at edge 3 after the drop; state=0. With the macro, lock_loss_count 0->1; 300 such losses saturate the count at 255.
- In RUN, pulse soft_reset_req for 1 cycle -> core_reset high for exactly 4 cycles, then 0. lock_loss_count is unchanged.
- Assert reset while in HOLD and in RUN -> next edge gives core_reset=1, seq_state=0, counter 0, lock_loss_count 0.
- soft_reset_req and pll_locked drop arriving together in RUN -> WAIT_LOCK, not HOLD. With the macro, lock_loss_count increments.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL-lock driven core reset sequencer.
package pll_reset_pkg;

    localparam int unsigned SEQ_STATE_W = 2;
    localparam int unsigned LOSS_CNT_W  = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

    typedef enum logic [SEQ_STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pll_reset_sequencer_lock_sync.sv
// Generic flop-chain synchroniser for a single asynchronous flag, cleared by a synchronous reset.
module lock_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the core in reset until PLL lock is qualified, then releases after a hold period.
// Optional lock-loss event counter enabled by defining PLL_LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RESET_HOLD_CYCLES  = 16,
    parameter int unsigned CNT_W              = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   soft_reset_req,
    output logic                   core_reset,
    output logic                   core_ready,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic [LOSS_CNT_W-1:0]  lock_loss_count
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic             locked_sync;
    seq_state_e       state_q;
    seq_state_e       state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pll_locked),
        .sync_out (locked_sync)
    );

    // State, shared counter and the reset outputs, all registered from next-state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            core_reset <= 1'b1;
            core_ready <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            core_reset <= (state_nxt != RUN);
            core_ready <= (state_nxt == RUN);
        end
    end

    // Lock loss always wins; the counter is cleared on every state change.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (locked_sync) begin
                    state_nxt = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!locked_sync) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_sync) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!locked_sync) begin
                    state_nxt = WAIT_LOCK;
                end else if (soft_reset_req) begin
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign seq_state = state_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    // Saturating count of RUN -> WAIT_LOCK transitions; soft resets go to HOLD and are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt_q <= '0;
        end else if ((state_q == RUN) && (state_nxt == WAIT_LOCK)
                     && (loss_cnt_q != LOSS_CNT_MAX)) begin
            loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with SYNC_STAGES=2, L=8, H=4.
module tb_pll_reset_sequencer;

    localparam int unsigned S = 2;
    localparam int unsigned L = 8;
    localparam int unsigned H = 4;
    localparam int unsigned RELEASE_EDGE = S + 1 + L + H;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       core_reset;
    logic       core_ready;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_count;

    int checks;
    int errors;
    logic [7:0] exp_loss;

    typedef struct {
        logic       rst;
        logic       lk;
        logic       sr;
        logic       exp_rst;
        logic [1:0] exp_st;
    } vec_t;

    vec_t vecs [19];

    pll_reset_sequencer #(
        .SYNC_STAGES        (S),
        .LOCK_STABLE_CYCLES (L),
        .RESET_HOLD_CYCLES  (H),
        .CNT_W              (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .soft_reset_req  (soft_reset_req),
        .core_reset      (core_reset),
        .core_ready      (core_ready),
        .seq_state       (seq_state),
        .lock_loss_count (lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic lk, input logic sr);
        reset          = r;
        pll_locked     = lk;
        soft_reset_req = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic note_loss();
`ifdef PLL_LOCK_LOSS_COUNT_EN
        if (exp_loss != 8'd255) exp_loss = exp_loss + 8'd1;
`endif
    endtask

    // Steady lock from a cleared synchroniser or a glitched one: release lands on the same edge.
    task automatic lock_release(input string nm);
        for (int e = 1; e <= int'(RELEASE_EDGE); e++) begin
            step(1'b0, 1'b1, 1'b0);
            chk({nm, " core_reset"}, 32'(core_reset), 32'(e < int'(RELEASE_EDGE)));
            if (e == 2) chk({nm, " state e2"}, 32'(seq_state), 32'd0);
        end
        chk({nm, " ready"}, 32'(core_ready), 32'd1);
        chk({nm, " state run"}, 32'(seq_state), 32'd3);
    endtask

    task automatic drop_lock(input string nm);
        step(1'b0, 1'b0, 1'b0);
        chk({nm, " e1 rst"}, 32'(core_reset), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk({nm, " e2 rst"}, 32'(core_reset), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk({nm, " e3 rst"}, 32'(core_reset), 32'd1);
        chk({nm, " e3 ready"}, 32'(core_ready), 32'd0);
        chk({nm, " e3 state"}, 32'(seq_state), 32'd0);
        note_loss();
        chk({nm, " loss count"}, 32'(lock_loss_count), 32'(exp_loss));
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        exp_loss       = 8'd0;
        reset          = 1'b1;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;

        for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0};
        for (int e = 1; e <= 16; e++) begin
            logic [1:0] st;
            if (e < int'(S + 1))          st = 2'd0;
            else if (e < int'(S + 1 + L)) st = 2'd1;
            else if (e < int'(RELEASE_EDGE)) st = 2'd2;
            else                          st = 2'd3;
            vecs[e + 2] = '{1'b0, 1'b1, 1'b0, logic'(e < int'(RELEASE_EDGE)), st};
        end

        // Power-on reset then first bring-up, checked edge by edge.
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].lk, vecs[i].sr);
            chk($sformatf("vec%0d core_reset", i), 32'(core_reset), 32'(vecs[i].exp_rst));
            chk($sformatf("vec%0d core_ready", i), 32'(core_ready), 32'(!vecs[i].exp_rst));
            chk($sformatf("vec%0d state", i), 32'(seq_state), 32'(vecs[i].exp_st));
            if (i < 3) begin
                chk("reset cnt", 32'(dut.cnt_q), 32'd0);
                chk("reset loss", 32'(lock_loss_count), 32'd0);
            end
        end

        // Soft reset: high for exactly H cycles, no lock-loss count.
        step(1'b0, 1'b1, 1'b1);
        chk("soft e1 rst", 32'(core_reset), 32'd1);
        chk("soft e1 state", 32'(seq_state), 32'd2);
        for (int k = 2; k <= int'(H); k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("soft e%0d rst", k), 32'(core_reset), 32'd1);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("soft release rst", 32'(core_reset), 32'd0);
        chk("soft release state", 32'(seq_state), 32'd3);
        chk("soft loss count", 32'(lock_loss_count), 32'(exp_loss));

        drop_lock("loss1");

        // One-cycle glitch at count 5 during STABILIZE restarts qualification.
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b0);
        chk("pre-glitch state", 32'(seq_state), 32'd1);
        chk("pre-glitch cnt", 32'(dut.cnt_q), 32'd4);
        step(1'b0, 1'b0, 1'b0);
        chk("glitch cnt", 32'(dut.cnt_q), 32'd5);
        lock_release("relock");

        // Soft request coinciding with synchronised lock loss goes to WAIT_LOCK.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("coincide state", 32'(seq_state), 32'd0);
        chk("coincide rst", 32'(core_reset), 32'd1);
        note_loss();
        chk("coincide loss", 32'(lock_loss_count), 32'(exp_loss));
        step(1'b0, 1'b0, 1'b0);
        chk("coincide after", 32'(seq_state), 32'd0);

        // Reset while in HOLD.
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0);
        chk("in hold", 32'(seq_state), 32'd2);
        step(1'b1, 1'b1, 1'b0);
        exp_loss = 8'd0;
        chk("hold reset rst", 32'(core_reset), 32'd1);
        chk("hold reset state", 32'(seq_state), 32'd0);
        chk("hold reset cnt", 32'(dut.cnt_q), 32'd0);
        chk("hold reset loss", 32'(lock_loss_count), 32'd0);
        lock_release("after hold reset");

        // Reset while in RUN with a nonzero loss count.
        drop_lock("loss2");
        lock_release("pre run reset");
        step(1'b1, 1'b1, 1'b0);
        exp_loss = 8'd0;
        chk("run reset rst", 32'(core_reset), 32'd1);
        chk("run reset ready", 32'(core_ready), 32'd0);
        chk("run reset state", 32'(seq_state), 32'd0);
        chk("run reset cnt", 32'(dut.cnt_q), 32'd0);
        chk("run reset loss", 32'(lock_loss_count), 32'd0);
        lock_release("after run reset");

        // 300 lock losses saturate the counter.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
            note_loss();
            for (int k = 0; k < int'(RELEASE_EDGE); k++) step(1'b0, 1'b1, 1'b0);
        end
        chk("sat state", 32'(seq_state), 32'd3);
        chk("sat rst", 32'(core_reset), 32'd0);
        chk("sat loss", 32'(lock_loss_count), 32'(exp_loss));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
